div_ctrl: RTL
=============

Name: div_ctrl

Overview:
Sequencer between the EX stage and the iterative 32-bit signed/unsigned divider. Accepts one divide request at a time and stalls the pipeline while the divider runs. Drives the divider's start/annul handshake, captures {remainder, quotient} into HI/LO results, and cleanly aborts an in-flight divide on pipeline flush.

Parameters:
ABORT_CYCLES, 3, cycles start is held low and annul held high after a flush, so the divider returns to its free state from any of its states.
DATA_W, 32, operand width; must equal the divider width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
req_i  in  1  EX-stage divide request; held high by EX until res_valid_o.
req_signed_i  in  1  1 = signed divide.
req_op1_i  in  DATA_W  dividend.
req_op2_i  in  DATA_W  divisor.
flush_i  in  1  pipeline flush; kills the current request.
stall_req_o  out  1  pipeline stall request.
res_valid_o  out  1  one-cycle result strobe.
hi_o  out  DATA_W  remainder.
lo_o  out  DATA_W  quotient.
div_start_o  out  1  to divider start.
div_annul_o  out  1  to divider annul.
div_signed_o  out  1  to divider signed select.
div_op1_o  out  DATA_W  to divider operand 1.
div_op2_o  out  DATA_W  to divider operand 2.
div_ret_i  in  2*DATA_W  from divider: {remainder, quotient}.
div_ready_i  in  1  from divider: result ready.

Behaviour:
- Reset (asynchronous): state IDLE; all div_* outputs, hi_o and lo_o are 0; res_valid_o is 0; abort counter is 0.
- stall_req_o is combinational: (IDLE & req_i & !flush_i) | BUSY | (ABORT & req_i).
- IDLE:
  - On req_i & !flush_i: register the operands and signed flag onto div_*_o, set div_start_o=1, and go to BUSY.
- BUSY:
  - Hold div_start_o=1.
  - On div_ready_i: register hi_o=div_ret_i[63:32] and lo_o=div_ret_i[31:0], set div_start_o=0, and go to DONE.
  - flush_i has priority over div_ready_i.
- DONE:
  - Lasts 1 cycle. res_valid_o = !flush_i. stall_req_o=0. Next state is IDLE.
  - div_ready_i is not sampled in DONE. The divider drops ready one cycle later because start is low.
- ABORT:
  - Entered from BUSY on flush_i: div_start_o=0, div_annul_o=1, counter loaded with ABORT_CYCLES-1.
  - Decrement the counter each cycle. At 0, clear annul and go to IDLE.
  - Requests are not accepted during ABORT.
- hi_o and lo_o hold their last value between strobes.
- Latency, request in cycle 0:
  - Normal divide: res_valid_o in cycle 37.
  - Divisor = 0: divider short path, res_valid_o in cycle 5 with hi_o=lo_o=0.
- Back-to-back: the earliest next request is accepted in the cycle after DONE. The divider has returned to free by the time it samples the new start.
- flush_i in IDLE or DONE: no request is launched and no result is strobed. Registered hi/lo may still update.

Optional Feature:
Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keep one entry: valid bit, signed flag, op1, op2, hi, lo.
  - The entry is written in BUSY when div_ready_i is accepted. It is cleared on reset. Aborted divides never write it.
  - IDLE req that exactly matches a valid entry: load hi_o/lo_o from the entry, keep div_start_o low, and go directly to DONE (res_valid_o in cycle 1).
- Undefined: no cache storage; every request runs the divider.

Test Plan:
- Unsigned 100/7 req in cycle 0 -> stall_req_o high cycles 0-36, res_valid_o in cycle 37, lo_o=14, hi_o=2.
- Signed 0xFFFFFF9C(-100)/7 -> lo_o=0xFFFFFFF2, hi_o=0xFFFFFFFE at cycle 37; signed 100/-7 -> lo_o=0xFFFFFFF2, hi_o=2.
- Divisor 0 -> res_valid_o in cycle 5, hi_o=lo_o=0, no stall after cycle 4.
- flush_i in cycle 10 of a divide -> div_annul_o high 3 cycles, div_start_o low, no res_valid_o. A new 9/3 request then gives lo_o=3, hi_o=0 with normal latency.
- Two back-to-back divides 50/5 then 51/5 -> two strobes 38 cycles apart: (lo 10, hi 0) then (lo 10, hi 1). div_start_o is low for at least 1 cycle between them.
- DIV_RESULT_CACHE_EN: repeat 100/7 -> res_valid_o in cycle 1, div_start_o never asserted. Change signed flag -> full 37-cycle latency.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequences one divide at a time through the iterative divider: start/annul handshake, HI/LO capture, flush abort.
// Optional single-entry result cache under macro DIV_RESULT_CACHE_EN.
module div_ctrl #(
  parameter int ABORT_CYCLES = 3,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                req_signed_i,
  input  logic [DATA_W-1:0]   req_op1_i,
  input  logic [DATA_W-1:0]   req_op2_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                res_valid_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic [2*DATA_W-1:0] div_ret_i,
  input  logic                div_ready_i
);

  localparam int CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                annul_q, annul_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                cache_hit;
  logic [DATA_W-1:0]   cache_hi, cache_lo;

`ifdef DIV_RESULT_CACHE_EN
  logic              ce_vld_q;
  logic              ce_sgn_q;
  logic [DATA_W-1:0] ce_op1_q, ce_op2_q, ce_hi_q, ce_lo_q;

  // Only completed divides are remembered; an aborted one never reaches div_ready_i acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_vld_q <= 1'b0;
      ce_sgn_q <= 1'b0;
      ce_op1_q <= '0;
      ce_op2_q <= '0;
      ce_hi_q  <= '0;
      ce_lo_q  <= '0;
    end else if (state_q == BUSY && !flush_i && div_ready_i) begin
      ce_vld_q <= 1'b1;
      ce_sgn_q <= sgn_q;
      ce_op1_q <= op1_q;
      ce_op2_q <= op2_q;
      ce_hi_q  <= div_ret_i[2*DATA_W-1:DATA_W];
      ce_lo_q  <= div_ret_i[DATA_W-1:0];
    end
  end

  assign cache_hit = ce_vld_q && (ce_sgn_q == req_signed_i) &&
                     (ce_op1_q == req_op1_i) && (ce_op2_q == req_op2_i);
  assign cache_hi  = ce_hi_q;
  assign cache_lo  = ce_lo_q;
`else
  assign cache_hit = 1'b0;
  assign cache_hi  = '0;
  assign cache_lo  = '0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    annul_d = annul_q;
    sgn_d   = sgn_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          if (cache_hit) begin
            hi_d    = cache_hi;
            lo_d    = cache_lo;
            state_d = DONE;
          end else begin
            sgn_d   = req_signed_i;
            op1_d   = req_op1_i;
            op2_d   = req_op2_i;
            start_d = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          cnt_d   = CNT_W'(ABORT_CYCLES - 1);
          state_d = ABORT;
        end else if (div_ready_i) begin
          hi_d    = div_ret_i[2*DATA_W-1:DATA_W];
          lo_d    = div_ret_i[DATA_W-1:0];
          start_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ABORT: begin
        // Annul is held long enough for the divider to fall back to free from any state.
        if (cnt_q == '0) begin
          annul_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      sgn_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      annul_q <= annul_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_req_o  = (state_q == IDLE && req_i && !flush_i) || (state_q == BUSY) ||
                        (state_q == ABORT && req_i);
  assign res_valid_o  = (state_q == DONE) && !flush_i;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = sgn_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;

endmodule
